// File: rtl/mem_bus_initiator_if.sv
// Core-side request/response bundle for mem_bus_initiator.
// master = core datapath, slave = bus initiator.
interface mem_bus_initiator_if #(
    parameter int WORD_SIZE = 16
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [WORD_SIZE-1:0] req_addr;
    logic [WORD_SIZE-1:0] req_wdata;
    logic                 rsp_valid;
    logic [WORD_SIZE-1:0] rsp_rdata;
    logic                 rsp_err;
    logic                 busy;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err,
        output busy
    );
endinterface

// File: rtl/mem_bus_initiator.sv
// Single-outstanding load/store initiator for the word bus (readM/writeM).
// Define MEM_TIMEOUT_EN to abort a stalled WAIT after TIMEOUT_CYCLES.
module mem_bus_initiator #(
    parameter int WORD_SIZE      = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mem_bus_initiator_if.slave   core,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    input  logic                 ackOutput
);

    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_WAIT = 3'b010;
    localparam logic [2:0] S_RESP = 3'b100;

    if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0]           state;
    logic [2:0]           state_nx;
    logic                 we_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] rdata_q;

    logic                 rd_seen;
    logic [WORD_SIZE-1:0] rd_data;
    logic                 wr_seen;
    logic                 seen_sync;
    logic                 cap_clr_n;

    logic                 accept;
    logic                 done;
    logic                 abort;

    assign accept = state[0] & core.req_valid;
    assign done   = state[1] & seen_sync;

    // One-hot state keeps the IDLE decode glitch-free for the capture clear.
    assign cap_clr_n = reset_n & ~state[0];

    always_ff @(posedge inputReady or negedge cap_clr_n) begin
        if (!cap_clr_n) begin
            rd_seen <= 1'b0;
            rd_data <= '0;
        end else if (readM && !rd_seen) begin
            rd_seen <= 1'b1;
            rd_data <= data;
        end
    end

    always_ff @(posedge ackOutput or negedge cap_clr_n) begin
        if (!cap_clr_n) begin
            wr_seen <= 1'b0;
        end else if (writeM) begin
            wr_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen_sync <= 1'b0;
        end else begin
            seen_sync <= rd_seen | wr_seen;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (!state[1]) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign abort = state[1] & ~seen_sync
                 & (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (state[1]) begin
            err_q <= abort;
        end
    end

    assign core.rsp_err = err_q;
`else
    assign abort        = 1'b0;
    assign core.rsp_err = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (1'b1)
            state[0]: if (core.req_valid) state_nx = S_WAIT;
            state[1]: if (done || abort)  state_nx = S_RESP;
            state[2]: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                we_q    <= core.req_we;
                addr_q  <= core.req_addr;
                wdata_q <= core.req_wdata;
            end
        end
    end

    // rd_data is frozen by rd_seen before seen_sync rises, so it is stable here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if (done && !we_q) begin
            rdata_q <= rd_data;
        end
    end

    assign readM   = state[1] & ~we_q;
    assign writeM  = state[1] & we_q;
    assign address = addr_q;
    assign data    = writeM ? wdata_q : 'z;

    assign core.req_ready = state[0];
    assign core.busy      = ~state[0];
    assign core.rsp_valid = state[2];
    assign core.rsp_rdata = rdata_q;

    a_one_strobe: assert property (
        @(posedge clk) disable iff (!reset_n) !(readM && writeM)
    );

    a_rsp_pulse: assert property (
        @(posedge clk) disable iff (!reset_n)
        core.rsp_valid |=> !core.rsp_valid
    );

endmodule
